// File: rtl/bsg_xor_descrambler.sv
// rtl/bsg_xor_descrambler.sv - frame-synchronised additive LFSR descrambler
// Hunts for the sync word, then XORs frame_len_p payload words with the keystream.
module bsg_xor_descrambler #(
    parameter logic [15:0] seed_p      = 16'hACE1,
    parameter logic [15:0] sync_p      = 16'hF628,
    parameter int          frame_len_p = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        v_i,
    input  logic [15:0] data_i,
    output logic        ready_o,
    output logic        v_o,
    output logic [15:0] data_o,
    input  logic        yumi_i,
    input  logic        resync_i,
    output logic        locked_o
);
    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;

    localparam logic [15:0] last_lp = 16'(frame_len_p - 1);

    state_e      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] cnt_q;
    logic        v_q;
    logic [15:0] data_q;

    logic [15:0] lfsr_d;
    logic        accept;
    logic        load;

    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign ready_o  = (state_q == HUNT) | ((~v_q | yumi_i) & ~resync_i);
    assign accept   = v_i & ready_o;
    // Only RUN-accepted words reach the output register; HUNT drops everything.
    assign load     = (state_q == RUN) & accept;
    assign v_o      = v_q;
    assign data_o   = data_q;
    assign locked_o = (state_q == RUN);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= HUNT;
            lfsr_q  <= seed_p;
            cnt_q   <= 16'h0000;
            v_q     <= 1'b0;
            data_q  <= 16'h0000;
        end else begin
            if (load) begin
                data_q <= data_i ^ lfsr_q;
                v_q    <= 1'b1;
            end else if (yumi_i) begin
                v_q    <= 1'b0;
            end

            case (state_q)
                HUNT: begin
                    cnt_q <= 16'h0000;
                    if (accept && (data_i == sync_p) && !resync_i) begin
                        state_q <= RUN;
                        lfsr_q  <= seed_p;
                    end
                end
                RUN: begin
                    if (resync_i) begin
                        state_q <= HUNT;
                        cnt_q   <= 16'h0000;
                    end else if (accept) begin
                        lfsr_q <= lfsr_d;
                        if (cnt_q == last_lp) begin
                            state_q <= HUNT;
                            cnt_q   <= 16'h0000;
                        end else begin
                            cnt_q <= cnt_q + 16'h0001;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_xor_descrambler.sv
// tb/tb_bsg_xor_descrambler.sv - scoreboard bench for bsg_xor_descrambler
module tb_bsg_xor_descrambler;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] SYNC = 16'hF628;
    localparam int          FLEN = 8;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic [15:0] data_i = 16'h0;
    logic        ready_o;
    logic        v_o;
    logic [15:0] data_o;
    logic        yumi_i = 1'b0;
    logic        resync_i = 1'b0;
    logic        locked_o;

    bsg_xor_descrambler #(.seed_p(SEED), .sync_p(SYNC), .frame_len_p(FLEN)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .resync_i(resync_i), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    logic [15:0] ks[0:FLEN-1];
    bit          m_lock = 1'b0;
    bit          m_v = 1'b0;
    int          m_cnt = 0;
    bit          prev_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // One clock of stimulus; the model decides acceptance from the handshake rules.
    task automatic step(input bit v, input logic [15:0] d, input bit y, input bit rs, input bit rst);
        bit rdy_exp;
        bit acc;
        bit ld;
        @(negedge clk);
        chk("v_o", v_o, m_v);
        chk("locked_o", locked_o, m_lock);
        if (prev_rst) chk("data_o_after_reset", data_o, 16'h0000);
        v_i = v; data_i = d; resync_i = rs; reset_i = rst;
        yumi_i = y & m_v & !rst;
        #1;
        prev_rst = rst;
        if (rst) begin
            exp_q.delete();
            m_v = 0; m_lock = 0; m_cnt = 0;
            return;
        end
        rdy_exp = !m_lock || ((!m_v || yumi_i) && !rs);
        chk("ready_o", ready_o, rdy_exp);
        acc = v && rdy_exp;
        ld = 0;
        if (!m_lock) begin
            if (acc && d == SYNC && !rs) begin
                m_lock = 1; m_cnt = 0;
            end
        end else if (rs) begin
            m_lock = 0; m_cnt = 0;
        end else if (acc) begin
            ld = 1;
            exp_q.push_back(d ^ ks[m_cnt]);
            m_cnt++;
            if (m_cnt == FLEN) begin
                m_lock = 0; m_cnt = 0;
            end
        end
        if (ld) m_v = 1;
        else if (yumi_i) m_v = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (v_o && yumi_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output actual=%h expected=none", data_o);
                end else begin
                    chk("data_o", data_o, exp_q.pop_front());
                end
            end
        end
    end

    logic [15:0] pay[0:FLEN-1];

    initial begin
        ks[0] = SEED;
        for (int i = 1; i < FLEN; i++) ks[i] = lfsr_next(ks[i-1]);
        chk("keystream0", ks[0], 16'hACE1);
        chk("keystream1", ks[1], 16'h59C3);

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // sync acquisition
        step(1, 16'h1234, 0, 0, 0);
        step(1, SYNC, 0, 0, 0);
        step(1, 16'h0000, 1, 0, 0);
        step(1, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);

        // full frame then a dropped word
        step(1, SYNC, 1, 0, 0);
        for (int i = 0; i < FLEN; i++) step(1, 16'h0000, 1, 0, 0);
        step(1, 16'h5555, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // backpressure
        step(1, SYNC, 0, 0, 0);
        step(1, 16'hA001, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 16'hB002, 0, 0, 0);
        step(1, 16'hB002, 1, 0, 0);
        step(1, 16'hC003, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);

        // resync mid-frame with a pending word
        step(1, SYNC, 0, 0, 0);
        step(1, 16'h1111, 1, 0, 0);
        step(1, 16'h2222, 1, 0, 0);
        step(1, 16'h3333, 0, 0, 0);
        step(1, 16'h4444, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // round trip of a random payload
        for (int i = 0; i < FLEN; i++) pay[i] = 16'($urandom);
        step(1, SYNC, 1, 0, 0);
        for (int i = 0; i < FLEN; i++) begin
            exp_q.push_back(pay[i]);
            step(1, pay[i] ^ ks[i], 1, 0, 0);
            void'(exp_q.pop_back());
        end
        step(0, 0, 1, 0, 0);

        // reset mid-frame
        step(1, SYNC, 0, 0, 0);
        step(1, 16'h7777, 0, 0, 0);
        step(1, 16'h8888, 0, 0, 1);
        step(1, SYNC, 0, 0, 0);
        step(1, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 3) == 0) ? SYNC : 16'($urandom);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end

        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

●
